// File: rtl/avalon_st_demultiplexer.sv
// 1:2 Avalon-ST packet demultiplexer: whole packets are steered to output ONE or TWO by the
// route bit of the SOP channel, each output behind a one-deep register; orphan beats are dropped.
module avalon_st_demultiplexer #(
    parameter int DATA_WIDTH    = 128,
    parameter int EMPTY_WIDTH   = 2,
    parameter int CHANNEL_WIDTH = 1,
    parameter int ROUTE_BIT     = 0,
    parameter int ERR_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [CHANNEL_WIDTH-1:0] avsi_channel,
    input  logic [DATA_WIDTH-1:0]    avsi_data,
    input  logic                     avsi_valid,
    input  logic                     avsi_sop,
    input  logic                     avsi_eop,
    input  logic [EMPTY_WIDTH-1:0]   avsi_empty,
    output logic                     avsi_ready,
    output logic [CHANNEL_WIDTH-1:0] avso_one_channel,
    output logic [DATA_WIDTH-1:0]    avso_one_data,
    output logic                     avso_one_valid,
    output logic                     avso_one_sop,
    output logic                     avso_one_eop,
    output logic [EMPTY_WIDTH-1:0]   avso_one_empty,
    input  logic                     avso_one_ready,
    output logic [CHANNEL_WIDTH-1:0] avso_two_channel,
    output logic [DATA_WIDTH-1:0]    avso_two_data,
    output logic                     avso_two_valid,
    output logic                     avso_two_sop,
    output logic                     avso_two_eop,
    output logic [EMPTY_WIDTH-1:0]   avso_two_empty,
    input  logic                     avso_two_ready,
    output logic [ERR_WIDTH-1:0]     err_count,
    output logic [1:0]               dbg_state
);

    // Handshake: a beat moves on any port in a cycle where valid and ready are both high
    // (readyLatency 0); a source holding valid without ready keeps its beat for the next cycle.

    localparam int BEAT_W = 2 + CHANNEL_WIDTH + EMPTY_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE1 = 2'd1,
        ROUTE2 = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  one_valid_q, one_valid_d;
    logic                  two_valid_q, two_valid_d;
    logic [BEAT_W-1:0]     one_beat_q, one_beat_d;
    logic [BEAT_W-1:0]     two_beat_q, two_beat_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;

    logic [BEAT_W-1:0]     in_beat;
    logic                  free_one, free_two;
    logic                  has_target, to_two;
    logic                  accept, load_one, load_two, err_bump;

    assign in_beat = {avsi_sop, avsi_eop, avsi_channel, avsi_empty, avsi_data};

    always_comb begin
        free_one   = !one_valid_q || avso_one_ready;
        free_two   = !two_valid_q || avso_two_ready;
        has_target = avsi_sop || (state_q != IDLE);
        to_two     = avsi_sop ? avsi_channel[ROUTE_BIT] : (state_q == ROUTE2);

        // Non-SOP beats in IDLE are always taken so they can be dropped without stalling.
        avsi_ready = 1'b0;
        if (!reset_n) begin
            avsi_ready = 1'b0;
        end else if (avsi_valid) begin
            avsi_ready = has_target ? (to_two ? free_two : free_one) : 1'b1;
        end else if (state_q == IDLE) begin
            avsi_ready = free_one && free_two;
        end else begin
            avsi_ready = (state_q == ROUTE2) ? free_two : free_one;
        end

        accept   = avsi_valid && avsi_ready;
        load_one = accept && has_target && !to_two;
        load_two = accept && has_target && to_two;

        one_valid_d = load_one || (one_valid_q && !free_one);
        two_valid_d = load_two || (two_valid_q && !free_two);
        one_beat_d  = load_one ? in_beat : one_beat_q;
        two_beat_d  = load_two ? in_beat : two_beat_q;

        state_d  = state_q;
        err_bump = 1'b0;
        if (accept) begin
            if (avsi_sop) begin
                // An SOP inside an open packet truncates it and starts the new one.
                err_bump = (state_q != IDLE);
                if (avsi_eop) begin
                    state_d = IDLE;
                end else begin
                    state_d = avsi_channel[ROUTE_BIT] ? ROUTE2 : ROUTE1;
                end
            end else if (state_q == IDLE) begin
                err_bump = 1'b1;
            end else if (avsi_eop) begin
                state_d = IDLE;
            end
        end

        err_d = err_q;
        if (err_bump && (err_q != {ERR_WIDTH{1'b1}})) begin
            err_d = err_q + ERR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            one_valid_q <= 1'b0;
            two_valid_q <= 1'b0;
            one_beat_q  <= '0;
            two_beat_q  <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            one_valid_q <= one_valid_d;
            two_valid_q <= two_valid_d;
            one_beat_q  <= one_beat_d;
            two_beat_q  <= two_beat_d;
            err_q       <= err_d;
        end
    end

    assign avso_one_valid = one_valid_q;
    assign avso_two_valid = two_valid_q;
    assign {avso_one_sop, avso_one_eop, avso_one_channel, avso_one_empty, avso_one_data} = one_beat_q;
    assign {avso_two_sop, avso_two_eop, avso_two_channel, avso_two_empty, avso_two_data} = two_beat_q;
    assign err_count = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_avalon_st_demultiplexer.sv
// Bench for avalon_st_demultiplexer: directed scenarios plus a random packet stream, all checked
// cycle by cycle against a behavioural model of two one-deep output slots and an open-packet route.
module tb_avalon_st_demultiplexer;

    localparam int DW      = 128;
    localparam int EW      = 2;
    localparam int CW      = 1;
    localparam int RB      = 0;
    localparam int ERRW    = 4;
    localparam int ERR_MAX = (1 << ERRW) - 1;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [CW-1:0] ch;
        logic [EW-1:0] empty;
        logic [DW-1:0] data;
    } beat_t;

    localparam int OW = 3 + 2 * $bits(beat_t) + ERRW;

    logic clk;
    logic reset_n;
    logic [CW-1:0] avsi_channel;
    logic [DW-1:0] avsi_data;
    logic avsi_valid, avsi_sop, avsi_eop;
    logic [EW-1:0] avsi_empty;
    logic avsi_ready;
    logic [CW-1:0] avso_one_channel, avso_two_channel;
    logic [DW-1:0] avso_one_data, avso_two_data;
    logic avso_one_valid, avso_one_sop, avso_one_eop, avso_one_ready;
    logic avso_two_valid, avso_two_sop, avso_two_eop, avso_two_ready;
    logic [EW-1:0] avso_one_empty, avso_two_empty;
    logic [ERRW-1:0] err_count;
    logic [1:0] dbg_state;

    avalon_st_demultiplexer #(
        .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW), .ROUTE_BIT(RB), .ERR_WIDTH(ERRW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .avsi_channel(avsi_channel), .avsi_data(avsi_data), .avsi_valid(avsi_valid),
        .avsi_sop(avsi_sop), .avsi_eop(avsi_eop), .avsi_empty(avsi_empty), .avsi_ready(avsi_ready),
        .avso_one_channel(avso_one_channel), .avso_one_data(avso_one_data),
        .avso_one_valid(avso_one_valid), .avso_one_sop(avso_one_sop), .avso_one_eop(avso_one_eop),
        .avso_one_empty(avso_one_empty), .avso_one_ready(avso_one_ready),
        .avso_two_channel(avso_two_channel), .avso_two_data(avso_two_data),
        .avso_two_valid(avso_two_valid), .avso_two_sop(avso_two_sop), .avso_two_eop(avso_two_eop),
        .avso_two_empty(avso_two_empty), .avso_two_ready(avso_two_ready),
        .err_count(err_count), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    beat_t m_slot[2];
    bit    m_v[2];
    int    m_route;   // 0 = no open packet, 1 = to ONE, 2 = to TWO
    int    m_err;
    bit    m_acc;
    beat_t stim_q[$];

    function automatic void m_reset();
        m_v[0] = 0; m_v[1] = 0;
        m_slot[0] = '0; m_slot[1] = '0;
        m_route = 0; m_err = 0; m_acc = 0;
    endfunction

    function automatic bit m_free(int k);
        return !m_v[k] || ((k == 0) ? avso_one_ready : avso_two_ready);
    endfunction

    function automatic int m_target();
        if (avsi_sop) return avsi_channel[RB] ? 2 : 1;
        return m_route;
    endfunction

    function automatic logic m_ready();
        int t;
        if (!reset_n) return 1'b0;
        if (avsi_valid) begin
            t = m_target();
            return (t == 0) ? 1'b1 : m_free(t - 1);
        end
        if (m_route == 0) return m_free(0) && m_free(1);
        return m_free(m_route - 1);
    endfunction

    function automatic void m_bump_err();
        if (m_err < ERR_MAX) m_err++;
    endfunction

    function automatic void m_step();
        bit fr[2];
        int t;
        beat_t b;
        fr[0] = m_free(0);
        fr[1] = m_free(1);
        m_acc = avsi_valid && m_ready();
        t = m_target();
        b = {avsi_sop, avsi_eop, avsi_channel, avsi_empty, avsi_data};
        for (int k = 0; k < 2; k++) begin
            if (m_acc && t == k + 1) begin
                m_slot[k] = b;
                m_v[k] = 1;
            end else if (fr[k]) begin
                m_v[k] = 0;
            end
        end
        if (m_acc) begin
            if (avsi_sop) begin
                if (m_route != 0) m_bump_err();
                m_route = avsi_eop ? 0 : t;
            end else if (m_route == 0) begin
                m_bump_err();
            end else if (avsi_eop) begin
                m_route = 0;
            end
        end
    endfunction

    function automatic logic [OW-1:0] model_obs();
        beat_t b1, b2;
        b1 = m_v[0] ? m_slot[0] : '0;
        b2 = m_v[1] ? m_slot[1] : '0;
        return {m_ready(), m_v[0], b1, m_v[1], b2, ERRW'(m_err)};
    endfunction

    function automatic logic [OW-1:0] dut_obs();
        beat_t b1, b2;
        b1 = avso_one_valid ? beat_t'({avso_one_sop, avso_one_eop, avso_one_channel, avso_one_empty, avso_one_data}) : '0;
        b2 = avso_two_valid ? beat_t'({avso_two_sop, avso_two_eop, avso_two_channel, avso_two_empty, avso_two_data}) : '0;
        return {avsi_ready, avso_one_valid, b1, avso_two_valid, b2, err_count};
    endfunction

    // ---------------- driver tasks ----------------
    function automatic logic [DW-1:0] rand_data();
        return DW'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    function automatic beat_t mk(bit sop, bit eop, int ch);
        beat_t b;
        b.sop = sop; b.eop = eop; b.ch = CW'(ch);
        b.empty = EW'($urandom()); b.data = rand_data();
        return b;
    endfunction

    task automatic drive_beat(beat_t b);
        avsi_valid = 1'b1;
        avsi_sop = b.sop; avsi_eop = b.eop; avsi_channel = b.ch;
        avsi_empty = b.empty; avsi_data = b.data;
    endtask

    task automatic drive_idle();
        avsi_valid = 1'b0;
        avsi_sop = 1'($urandom()); avsi_eop = 1'($urandom()); avsi_channel = CW'($urandom());
        avsi_empty = EW'($urandom()); avsi_data = rand_data();
    endtask

    task automatic advance();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_packet();
        int len;
        int ch;
        len = $urandom_range(1, 4);
        ch = $urandom_range(0, 1);
        for (int i = 0; i < len; i++) begin
            stim_q.push_back(mk((i == 0) && ($urandom_range(0, 9) != 0),
                                (i == len - 1) && ($urandom_range(0, 9) != 0), ch));
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        avso_one_ready = 1'b1; avso_two_ready = 1'b1;
        drive_beat(mk(1, 0, 1));
        #2;
        n_vec++;
        if (dut_obs() !== '0) begin
            n_err++;
            $display("FAIL reset_async: got %h want 0", dut_obs());
        end
        @(posedge clk); #1;
        n_vec++;
        if (dut_obs() !== '0) begin
            n_err++;
            $display("FAIL reset_held: got %h want 0", dut_obs());
        end
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        drive_idle();
        advance();
    endtask

    task automatic test_orphans();
        avso_one_ready = 1'b1; avso_two_ready = 1'b1;
        for (int i = 0; i < 3; i++) stim_q.push_back(mk(0, i == 2, $urandom_range(0, 1)));
        for (int c = 0; c < 4; c++) begin
            if (stim_q.size() > 0) drive_beat(stim_q[0]); else drive_idle();
            @(negedge clk); n_vec++;
            if (dut_obs() !== model_obs()) begin
                n_err++;
                $display("FAIL orphans cyc %0d: got %h want %h", c, dut_obs(), model_obs());
            end
            advance();
            if (m_acc) void'(stim_q.pop_front());
        end
        n_vec++;
        if (err_count !== 4'd3) begin
            n_err++;
            $display("FAIL orphan_count: got %0d want 3", err_count);
        end
        stim_q.push_back(mk(1, 0, 0));
        stim_q.push_back(mk(0, 0, 0));
        stim_q.push_back(mk(1, 1, 1));
        for (int c = 0; c < 5; c++) begin
            if (stim_q.size() > 0) drive_beat(stim_q[0]); else drive_idle();
            @(negedge clk); n_vec++;
            if (dut_obs() !== model_obs()) begin
                n_err++;
                $display("FAIL truncate cyc %0d: got %h want %h", c, dut_obs(), model_obs());
            end
            advance();
            if (m_acc) void'(stim_q.pop_front());
        end
        n_vec++;
        if (err_count !== 4'd4) begin
            n_err++;
            $display("FAIL truncate_count: got %0d want 4", err_count);
        end
    endtask

    task automatic test_err_saturate();
        avso_one_ready = 1'b1; avso_two_ready = 1'b1;
        for (int i = 0; i < 14; i++) stim_q.push_back(mk(0, 0, $urandom_range(0, 1)));
        for (int c = 0; c < 16; c++) begin
            if (stim_q.size() > 0) drive_beat(stim_q[0]); else drive_idle();
            @(negedge clk); n_vec++;
            if (dut_obs() !== model_obs()) begin
                n_err++;
                $display("FAIL err_sat cyc %0d: got %h want %h", c, dut_obs(), model_obs());
            end
            advance();
            if (m_acc) void'(stim_q.pop_front());
        end
        n_vec++;
        if (err_count !== 4'hF) begin
            n_err++;
            $display("FAIL err_saturated: got %0d want 15", err_count);
        end
    endtask

    task automatic test_single_packet();
        avso_one_ready = 1'b1; avso_two_ready = 1'b1;
        for (int i = 0; i < 4; i++) stim_q.push_back(mk(i == 0, i == 3, 0));
        for (int c = 0; c < 7; c++) begin
            if (stim_q.size() > 0) drive_beat(stim_q[0]); else drive_idle();
            @(negedge clk); n_vec++;
            if (dut_obs() !== model_obs()) begin
                n_err++;
                $display("FAIL single_pkt cyc %0d: got %h want %h", c, dut_obs(), model_obs());
            end
            advance();
            if (m_acc) void'(stim_q.pop_front());
        end
    endtask

    task automatic test_alternating();
        avso_one_ready = 1'b1; avso_two_ready = 1'b1;
        for (int i = 0; i < 4; i++) stim_q.push_back(mk(1, 1, (i % 2 == 0) ? 1 : 0));
        for (int c = 0; c < 6; c++) begin
            if (stim_q.size() > 0) drive_beat(stim_q[0]); else drive_idle();
            @(negedge clk); n_vec++;
            if (dut_obs() !== model_obs()) begin
                n_err++;
                $display("FAIL alternating cyc %0d: got %h want %h", c, dut_obs(), model_obs());
            end
            advance();
            if (m_acc) void'(stim_q.pop_front());
        end
    endtask

    task automatic test_stall_two();
        for (int i = 0; i < 3; i++) stim_q.push_back(mk(i == 0, i == 2, 1));
        for (int c = 0; c < 10; c++) begin
            avso_one_ready = 1'b1;
            avso_two_ready = !(c >= 1 && c < 6);
            if (stim_q.size() > 0) drive_beat(stim_q[0]); else drive_idle();
            @(negedge clk); n_vec++;
            if (dut_obs() !== model_obs()) begin
                n_err++;
                $display("FAIL stall_two cyc %0d: got %h want %h", c, dut_obs(), model_obs());
            end
            advance();
            if (m_acc) void'(stim_q.pop_front());
        end
    endtask

    task automatic test_isolation();
        stim_q.push_back(mk(1, 1, 1));
        for (int i = 0; i < 4; i++) stim_q.push_back(mk(i == 0, i == 3, 0));
        for (int c = 0; c < 10; c++) begin
            avso_one_ready = 1'b1;
            avso_two_ready = (c >= 8);
            if (stim_q.size() > 0) drive_beat(stim_q[0]); else drive_idle();
            @(negedge clk); n_vec++;
            if (dut_obs() !== model_obs()) begin
                n_err++;
                $display("FAIL isolation cyc %0d: got %h want %h", c, dut_obs(), model_obs());
            end
            advance();
            if (m_acc) void'(stim_q.pop_front());
        end
    endtask

    task automatic test_reset_mid();
        avso_one_ready = 1'b1; avso_two_ready = 1'b1;
        for (int i = 0; i < 4; i++) stim_q.push_back(mk(i == 0, i == 3, 1));
        for (int c = 0; c < 2; c++) begin
            drive_beat(stim_q[0]);
            @(negedge clk); n_vec++;
            if (dut_obs() !== model_obs()) begin
                n_err++;
                $display("FAIL pre_reset cyc %0d: got %h want %h", c, dut_obs(), model_obs());
            end
            advance();
            if (m_acc) void'(stim_q.pop_front());
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (dut_obs() !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got %h want 0", dut_obs());
        end
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        drive_idle();
        advance();
        // Remaining beats of the cut packet are now orphans, then a fresh packet to ONE.
        for (int i = 0; i < 3; i++) stim_q.push_back(mk(i == 0, i == 2, 0));
        for (int c = 0; c < 8; c++) begin
            if (stim_q.size() > 0) drive_beat(stim_q[0]); else drive_idle();
            @(negedge clk); n_vec++;
            if (dut_obs() !== model_obs()) begin
                n_err++;
                $display("FAIL post_reset cyc %0d: got %h want %h", c, dut_obs(), model_obs());
            end
            advance();
            if (m_acc) void'(stim_q.pop_front());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if (stim_q.size() == 0) gen_packet();
            avso_one_ready = ($urandom_range(0, 3) != 0);
            avso_two_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) drive_idle(); else drive_beat(stim_q[0]);
            @(negedge clk); n_vec++;
            if (dut_obs() !== model_obs()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %h want %h", c, dut_obs(), model_obs());
            end
            advance();
            if (m_acc) void'(stim_q.pop_front());
        end
        stim_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_orphans();
        test_err_saturate();
        test_single_packet();
        test_alternating();
        test_stall_two();
        test_isolation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
